// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Data widths, requester slots, pointer width and the INIT/RUN state encoding.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_WB     = 3;
  localparam int PTR_W      = 2;

  // Requester slots on the writeback bus
  localparam int WB_ALU    = 0;
  localparam int WB_MULDIV = 1;
  localparam int WB_LSU    = 2;

  // Last register index touched by the power-up clearing sweep
  localparam int SWEEP_LAST = 31;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb.sv
// Round-robin grant selection for the writeback requesters.
// The search starts at the pointer and wraps past the last requester back to 0.
// The first valid requester wins. The pointer then moves to the slot after the winner.
module wb_rr_arb
  import regfile_pkg::*;
#(
  parameter int N_REQ = regfile_pkg::NUM_WB
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] ptr_nxt_o
);

  logic [PTR_W:0] idx;
  logic           found;

  // Scan requesters in priority order starting at the pointer; grant the first valid one
  always_comb begin
    gnt_o     = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N_REQ)) begin
        idx = idx - (PTR_W+1)'(N_REQ);
      end
      if (!found && valid_i[idx[PTR_W-1:0]]) begin
        found                  = 1'b1;
        gnt_o[idx[PTR_W-1:0]]  = 1'b1;
        ptr_nxt_o              = (idx == (PTR_W+1)'(N_REQ-1)) ? '0 : PTR_W'(idx + 1'b1);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback port arbiter.
// Three writeback sources (ALU, MUL/DIV, LSU) share one write port through round-robin arbitration.
// An accepted write appears on rd0_o / rd0_value_o one cycle after it is accepted.
// Optional macro REGFILE_INIT_SWEEP_EN: when it is defined, reset first enters an INIT sweep.
// The sweep writes zero to x1..x31 before any requester is served.
// When the macro is undefined, reset goes straight to RUN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_WB = regfile_pkg::NUM_WB
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_WB-1:0]                   wb_valid_i,
  input  logic [NUM_WB-1:0][REG_ADDR_W-1:0]   wb_rd_i,
  input  logic [NUM_WB-1:0][XLEN-1:0]         wb_value_i,
  output logic [NUM_WB-1:0]                   wb_ready_o,
  output logic [REG_ADDR_W-1:0]               rd0_o,
  output logic [XLEN-1:0]                     rd0_value_o,
  output logic                                init_done_o
);

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_nxt;
  logic [NUM_WB-1:0]      gnt;
  logic [REG_ADDR_W-1:0]  rd0_q, rd0_d, sel_rd;
  logic [XLEN-1:0]        val_q, val_d, sel_val;

`ifdef REGFILE_INIT_SWEEP_EN
  logic [REG_ADDR_W-1:0]  cnt_q, cnt_d;
  localparam state_e RST_STATE = ST_INIT;
`else
  localparam state_e RST_STATE = ST_RUN;
`endif

  wb_rr_arb #(
    .N_REQ(NUM_WB)
  ) u_arb (
    .valid_i  (wb_valid_i),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .ptr_nxt_o(ptr_nxt)
  );

  // Grants reach requesters only in RUN, and never while reset is asserted
  assign wb_ready_o = (state_q == ST_RUN && !rst_i) ? gnt : '0;

  // Route the granted requester's index and data toward the write port
  always_comb begin
    sel_rd  = '0;
    sel_val = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_ready_o[k]) begin
        sel_rd  = wb_rd_i[k];
        sel_val = wb_value_i[k];
      end
    end
  end

  // Next-state logic: INIT sweeps x1..x31 with zero; RUN forwards the granted write or idles with rd=0
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd0_d   = '0;
    val_d   = val_q;
`ifdef REGFILE_INIT_SWEEP_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef REGFILE_INIT_SWEEP_EN
        rd0_d = cnt_q;
        val_d = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == REG_ADDR_W'(SWEEP_LAST)) begin
          state_d = ST_RUN;
        end
`endif
      end
      ST_RUN: begin
        if (|wb_ready_o) begin
          rd0_d = sel_rd;
          val_d = sel_val;
          ptr_d = ptr_nxt;
        end
      end
      default: ;
    endcase
  end

  // State, pointer and write-port registers; reset aborts any sweep or pending write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      rd0_q   <= '0;
      val_q   <= '0;
`ifdef REGFILE_INIT_SWEEP_EN
      cnt_q   <= REG_ADDR_W'(1);
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rd0_q   <= rd0_d;
      val_q   <= val_d;
`ifdef REGFILE_INIT_SWEEP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rd0_o       = rd0_q;
  assign rd0_value_o = val_q;
  assign init_done_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter.
// Expected write-port contents are queued each cycle and compared the following cycle.
// The build option REGFILE_INIT_SWEEP_EN is honoured.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

`ifdef REGFILE_INIT_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           valid;
  logic [2:0][4:0]      rd;
  logic [2:0][31:0]     val;
  logic [2:0]           wb_ready_o;
  logic [4:0]           rd0_o;
  logic [31:0]          rd0_value_o;
  logic                 init_done_o;

  regfile_wb_arbiter #(.NUM_WB(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_valid_i (valid),
    .wb_rd_i    (rd),
    .wb_value_i (val),
    .wb_ready_o (wb_ready_o),
    .rd0_o      (rd0_o),
    .rd0_value_o(rd0_value_o),
    .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  wr_t          sb[$];
  int           glog[$];
  int           n_vec = 0;
  int           n_err = 0;
  bit           m_run = 1'b0;
  int           m_cnt = 1;
  int           m_ptr = 0;
  logic [31:0]  m_last = '0;
  int           left[3];
  logic [31:0]  shadow[32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (p + k) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk_grant(input string tag, input int i, input int exp);
    if (i < glog.size()) chk(tag, 64'(glog[i]), 64'(exp));
    else                 chk(tag, 64'(-1), 64'(exp));
  endtask

  // One clock: check this cycle's outputs, predict next cycle's, and let requesters consume grants
  task automatic cycle();
    wr_t        e;
    int         g;
    logic [2:0] exp_rdy;
    logic [2:0] acc;
    @(negedge clk);
    g       = (m_run && !rst) ? rr_pick(valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    acc     = '0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rd0", 64'(rd0_o), 64'(e.rd));
      chk("rd0_value", 64'(rd0_value_o), 64'(e.val));
      chk("init_done", 64'(init_done_o), 64'(m_run));
      chk("ready", 64'(wb_ready_o), 64'(exp_rdy));
    end
    if (rd0_o != 5'd0) shadow[rd0_o] = rd0_value_o;
    for (int k = 0; k < 3; k++) if (wb_ready_o[k]) glog.push_back(k);
    if (rst) begin
      e.rd = '0; e.val = '0;
      m_ptr = 0; m_run = !SWEEP; m_cnt = 1; m_last = '0;
    end else if (!m_run) begin
      e.rd = 5'(m_cnt); e.val = '0; m_last = '0;
      if (m_cnt == 31) m_run = 1'b1;
      m_cnt++;
    end else if (g >= 0) begin
      e.rd = rd[g]; e.val = val[g]; m_last = val[g];
      m_ptr = (g + 1) % 3;
      acc[g] = 1'b1;
    end else begin
      e.rd = '0; e.val = m_last;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (acc[k]) begin
        if (left[k] > 0) begin
          left[k]--;
          rd[k]  = 5'($urandom_range(1, 31));
          val[k] = $urandom;
        end else begin
          valid[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic req(input int k, input logic [4:0] r, input logic [31:0] v, input int extra);
    valid[k] = 1'b1;
    rd[k]    = r;
    val[k]   = v;
    left[k]  = extra;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (valid != 3'b000 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", 64'(valid), 64'(0));
  endtask

  initial begin
    int exp_c[6];
    exp_c = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1; valid = '0; rd = '0; val = '0;
    for (int k = 0; k < 3; k++) left[k] = 0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'hFFFF_FFFF;

    // Reset, with a MUL/DIV request already raised while reset is still high
    cycle();
    req(WB_MULDIV, 5'd7, 32'h0000_7777, 0);
    cycle();
    glog.delete();
    rst = 1'b0;
    drain(40);
    chk_grant("first_grant_muldiv", 0, 1);
    if (SWEEP) begin
      for (int i = 1; i < 32; i++) chk($sformatf("sweep_x%0d", i), 64'(shadow[i]), 64'(0));
    end
    cycle();

    // Single LSU request
    req(WB_LSU, 5'd5, 32'hDEAD_BEEF, 0);
    cycle();
    chk("lsu_ready", 64'(valid[WB_LSU]), 64'(0));
    cycle();
    cycle();

    // Contention from pointer 0: two writes per requester
    glog.delete();
    for (int k = 0; k < 3; k++) req(k, 5'($urandom_range(1, 31)), $urandom, 1);
    drain(20);
    for (int i = 0; i < 6; i++) chk_grant($sformatf("rr_order%0d", i), i, exp_c[i]);

    // x0 write consumes the grant and advances the pointer
    glog.delete();
    req(WB_ALU, 5'd0, 32'h0000_1234, 0);
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) req(k, 5'($urandom_range(1, 31)), $urandom, 0);
    drain(10);
    chk_grant("x0_grant", 0, 0);
    chk_grant("after_x0", 1, 1);

    // Random traffic, requests held until accepted
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 3; k++)
        if (!valid[k] && $urandom_range(0, 1) == 1)
          req(k, 5'($urandom_range(0, 31)), $urandom, 0);
      cycle();
    end
    drain(20);

    // Reset in the middle of contention
    for (int k = 0; k < 3; k++) req(k, 5'($urandom_range(1, 31)), $urandom, 0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drain(60);

    // Reset again after nine cycles (mid-sweep at counter 10 when the sweep is built in)
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (9) cycle();
    req(WB_LSU, 5'd9, 32'hA5A5_0009, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drain(60);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NUM_WB, default 3: number of writeback requesters sharing the register file write port (fixed at 3 for this release).
REQ-002 clk_i  input  1  core clock; one clock domain; all outputs registered on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 wb_valid_i  input  3  per-requester write request (bit 0 ALU, bit 1 MUL/DIV, bit 2 LSU).
REQ-005 wb_rd_i  input  3x5  per-requester destination register index.
REQ-006 wb_value_i  input  3x32  per-requester write data.
REQ-007 wb_ready_o  input-side handshake output  3  per-requester accept; at most one bit high per cycle.
REQ-008 rd0_o  output  5  register file write index; 0 = no write.
REQ-009 rd0_value_o  output  32  register file write data.
REQ-010 init_done_o  output  1  high once the write port is available to requesters.

Function
REQ-011 Transfer on requester k occurs in a cycle where wb_valid_i[k] and wb_ready_o[k] are both high; a requester SHALL hold valid, rd and value stable until accepted.
REQ-012 wb_ready_o SHALL be combinational from wb_valid_i, arbiter pointer and state; all zero unless state is RUN.
REQ-013 Arbitration SHALL be round-robin: search order starts at pointer p, wraps 2->0; first valid requester is granted.
REQ-014 After a grant to k, p SHALL become (k+1) mod 3; p unchanged in cycles with no grant.
REQ-015 Latency: accepted rd/value SHALL appear on rd0_o/rd0_value_o the cycle after acceptance; register file commits at the following edge.
REQ-016 In RUN cycles with no grant, rd0_o SHALL be 0 and rd0_value_o SHALL hold its previous value.
REQ-017 Requests with rd=0 SHALL be accepted normally and drive rd0_o=0 (discarded write); they consume the grant and advance p.
REQ-018 Throughput: one accepted write per cycle, back-to-back, no bubbles.
REQ-019 States: INIT (sweep) and RUN; INIT->RUN when sweep counter reaches 31; RUN is terminal until reset.
REQ-020 In INIT, a 5-bit counter SHALL run 1..31, one per cycle, driving rd0_o=counter, rd0_value_o=0; wb_ready_o all zero.
REQ-021 init_done_o SHALL be high exactly in RUN; first grant possible in the first RUN cycle.

Reset
REQ-022 On rst_i: rd0_o=0, rd0_value_o=0, p=0, init_done_o=0, state=INIT (or RUN per REQ-025), sweep counter=1.
REQ-023 Reset asserted mid-sweep or mid-transfer SHALL abort it; no write issued in the cycle following reset; sweep restarts from x1.
REQ-024 Simultaneous rst_i and valid: no acceptance that cycle.

Configuration
REQ-025 Macro REGFILE_INIT_SWEEP_EN: defined -> INIT sweep per REQ-020 (31 cycles, init_done_o rises on the 32nd cycle after reset release); undefined -> reset enters RUN directly, init_done_o=1 the first cycle after reset, INIT logic and counter absent.

Structure
REQ-026 Shared package regfile_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_WB=3, requester index constants and the INIT/RUN state enum.
REQ-027 Round-robin grant logic SHALL be sub-module wb_rr_arb (inputs valid, pointer; outputs one-hot grant, next pointer).

Verification
REQ-028 Sweep: macro defined, reset release -> rd0_o = 1,2,...,31 on consecutive cycles with value 0, then init_done_o=1; readback of x1..x31 = 0.
REQ-029 Contention: all three valid continuously from RUN with p=0 -> grants 0,1,2,0,1,2; rd0_o follows requested rd one cycle later.
REQ-030 Single requester: LSU valid rd=5 value 0xDEADBEEF -> ready same cycle, rd0_o=5/rd0_value_o=0xDEADBEEF next cycle, rd0_o=0 after.
REQ-031 x0 write: ALU rd=0 value 0x1234 -> accepted, rd0_o stays 0, p advances to 1.
REQ-032 Reset mid-sweep at counter 10 -> next cycle rd0_o=0, sweep restarts at 1, no requester accepted.
REQ-033 Macro undefined: reset release -> init_done_o=1 next cycle; MUL/DIV request accepted in that cycle.
